// File: rtl/fetch_data_mem_if.sv
// Bus bundle for fetch_data_mem: boot-loader byte stream, instruction fetch port and data port.
// Member names mirror the flattened io_* port names of the original block (io.ld_valid == io_ld_valid).
interface fetch_data_mem_if #(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned ADDR_WIDTH  = 64
);
  logic                      ld_valid;
  logic [7:0]                ld_byte;
  logic                      ld_last;
  logic                      ld_ready;
  logic                      ready;
  logic                      if_req;
  logic [ADDR_WIDTH-1:0]     if_addr;
  logic                      if_valid;
  logic [32*FETCH_WIDTH-1:0] if_inst;
  logic                      dm_req;
  logic                      dm_we;
  logic [ADDR_WIDTH-1:0]     dm_addr;
  logic [31:0]               dm_wdata;
  logic [2:0]                dm_func3;
  logic                      dm_valid;
  logic [31:0]               dm_rdata;
  logic                      dm_misalign;

  modport master (
    output ld_valid, ld_byte, ld_last, if_req, if_addr,
           dm_req, dm_we, dm_addr, dm_wdata, dm_func3,
    input  ld_ready, ready, if_valid, if_inst, dm_valid, dm_rdata, dm_misalign
  );

  modport slave (
    input  ld_valid, ld_byte, ld_last, if_req, if_addr,
           dm_req, dm_we, dm_addr, dm_wdata, dm_func3,
    output ld_ready, ready, if_valid, if_inst, dm_valid, dm_rdata, dm_misalign
  );
endinterface

// File: rtl/fetch_data_mem.sv
// Unified rv32i instruction/data memory: byte-stream boot loader, multi-lane fetch and one
// load/store per cycle, both with one-cycle registered read latency.
module fetch_data_mem #(
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter bit          BOOT_SKIP   = 1'b0
) (
  input logic             clock,
  input logic             reset,
  fetch_data_mem_if.slave io
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t state_q, state_d;
  logic [AW+1:0] ptr_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          ld_fire, if_fire, dm_fire;
  logic [AW-1:0] if_idx, dm_idx;
  logic [1:0]    dm_off, dm_size;
  logic          dm_bad;

  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;

  logic                      if_valid_q;
  logic [32*FETCH_WIDTH-1:0] inst_q;
  logic                      dm_valid_q, mis_q, rd_zero_q;
  logic [31:0]               rd_word_q;
  logic [2:0]                rd_f3_q;
  logic [1:0]                rd_off_q;
  logic [7:0]                rd_byte;
  logic [15:0]               rd_half;

  // State register and boot pointer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT_SKIP ? S_RUN : S_LOAD;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (ld_fire) ptr_q <= ptr_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    io.ld_ready = 1'b0;
    io.ready    = 1'b0;
    case (state_q)
      S_LOAD: begin
        io.ld_ready = 1'b1;
        if (io.ld_valid && io.ld_last) state_d = S_RUN;
      end
      S_RUN: io.ready = 1'b1;
      default: state_d = S_LOAD;
    endcase
  end

  assign ld_fire = (state_q == S_LOAD) && io.ld_valid;
  assign if_fire = (state_q == S_RUN) && io.if_req;
  assign dm_fire = (state_q == S_RUN) && io.dm_req;

  assign if_idx  = io.if_addr[AW+1:2];
  assign dm_idx  = io.dm_addr[AW+1:2];
  assign dm_off  = io.dm_addr[1:0];
  assign dm_size = io.dm_func3[1:0];

  always_comb begin
    dm_bad = 1'b0;
    if (io.dm_func3 inside {3'b011, 3'b110, 3'b111}) dm_bad = 1'b1;
    else if (dm_size == 2'b01 && dm_off[0])           dm_bad = 1'b1;
    else if (dm_size == 2'b10 && dm_off != 2'b00)     dm_bad = 1'b1;
  end

  // Loader and store data share one byte-enabled write port; the FSM never enables both.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_be   = '0;
    wr_data = '0;
    if (ld_fire) begin
      wr_en   = 1'b1;
      wr_idx  = ptr_q[AW+1:2];
      wr_be   = 4'b0001 << ptr_q[1:0];
      wr_data = {4{io.ld_byte}};
    end else if (dm_fire && io.dm_we && !dm_bad) begin
      wr_en  = 1'b1;
      wr_idx = dm_idx;
      case (dm_size)
        2'b00: begin
          wr_be   = 4'b0001 << dm_off;
          wr_data = {4{io.dm_wdata[7:0]}};
        end
        2'b01: begin
          wr_be   = dm_off[1] ? 4'b1100 : 4'b0011;
          wr_data = {2{io.dm_wdata[15:0]}};
        end
        default: begin
          wr_be   = 4'b1111;
          wr_data = io.dm_wdata;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Registered reads sample the array before this edge's write lands (read-before-write).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_valid_q <= 1'b0;
      inst_q     <= '0;
      dm_valid_q <= 1'b0;
      mis_q      <= 1'b0;
      rd_zero_q  <= 1'b1;
      rd_word_q  <= '0;
      rd_f3_q    <= '0;
      rd_off_q   <= '0;
    end else begin
      if_valid_q <= if_fire;
      dm_valid_q <= dm_fire;
      mis_q      <= dm_fire && dm_bad;
      if (if_fire) begin
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
          inst_q[32*i +: 32] <= mem[if_idx + AW'(i)];
        end
      end
      if (dm_fire) begin
        rd_word_q <= mem[dm_idx];
        rd_f3_q   <= io.dm_func3;
        rd_off_q  <= dm_off;
        rd_zero_q <= io.dm_we || dm_bad;
      end
    end
  end

  assign rd_byte = rd_word_q[{rd_off_q, 3'b000} +: 8];
  assign rd_half = rd_off_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];

  always_comb begin
    io.dm_rdata = '0;
    if (!rd_zero_q) begin
      case (rd_f3_q)
        3'b000:  io.dm_rdata = {{24{rd_byte[7]}}, rd_byte};
        3'b100:  io.dm_rdata = {24'h0, rd_byte};
        3'b001:  io.dm_rdata = {{16{rd_half[15]}}, rd_half};
        3'b101:  io.dm_rdata = {16'h0, rd_half};
        3'b010:  io.dm_rdata = rd_word_q;
        default: io.dm_rdata = '0;
      endcase
    end
  end

  assign io.if_valid    = if_valid_q;
  assign io.if_inst     = inst_q;
  assign io.dm_valid    = dm_valid_q;
  assign io.dm_misalign = mis_q;
endmodule

// File: doc/fetch_data_mem.md
# fetch_data_mem

Parametrised unified instruction/data memory for the rv32i core. Serves FETCH_WIDTH consecutive instructions per fetch and one load/store per cycle, both with one-cycle registered read latency, plus byte/halfword/word stores and sign/zero-extended loads per func3. After reset it runs a byte-stream boot-loader phase that fills the array from an external source, replacing file-based preloading. It then switches to run mode. It sits between IF/ID, the EX/MEM stage and the LSU.

## Interface
Parameters:
- DEPTH_WORDS, 16384: number of 32-bit words; power of two, at least 4.
- FETCH_WIDTH, 2: instructions returned per fetch; 1..4.
- ADDR_WIDTH, 64: width of the address ports.
- BOOT_SKIP, 0: 1 makes reset enter RUN directly, skipping the boot loader.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_ld_valid  in  1  boot byte valid.
- io_ld_byte  in  8  boot byte.
- io_ld_last  in  1  final boot byte.
- io_ld_ready  out  1  loader accepts a byte.
- io_ready  out  1  memory is in RUN.
- io_if_req  in  1  fetch request.
- io_if_addr  in  ADDR_WIDTH  fetch byte address.
- io_if_valid  out  1  fetch data valid.
- io_if_inst  out  32*FETCH_WIDTH  lane i occupies bits [32i+31:32i].
- io_dm_req  in  1  data request.
- io_dm_we  in  1  1 = store, 0 = load.
- io_dm_addr  in  ADDR_WIDTH  data byte address.
- io_dm_wdata  in  32  store data.
- io_dm_func3  in  3  RISC-V access-size code.
- io_dm_valid  out  1  load or store completion.
- io_dm_rdata  out  32  extended load data.
- io_dm_misalign  out  1  access rejected.

## Operation
- Storage: DEPTH_WORDS x 32-bit, little-endian. Word index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses alias modulo the memory size. The array is never cleared by reset.
- States: LOAD and RUN.
  - Reset enters LOAD, or RUN when BOOT_SKIP=1.
  - LOAD -> RUN on an accepted byte with io_ld_last=1.
  - RUN is held until the next reset.
- LOAD:
  - io_ld_ready=1.
  - Each accepted byte (valid and ready) is written at byte pointer ptr, then ptr increments. ptr resets to 0 and wraps at DEPTH_WORDS*4.
  - io_if_req and io_dm_req are ignored; no valid is produced.
- RUN:
  - io_ld_ready=0 and io_ready=1.
  - Fetch: lane i returns word (index(io_if_addr)+i) mod DEPTH_WORDS. The word index wraps at the top of memory.
- Loads by func3:
  - 000 LB and 100 LBU: sign- or zero-extended byte at addr[1:0].
  - 001 LH and 101 LHU: sign- or zero-extended halfword at addr[1].
  - 010 LW: full word.
- Stores by func3:
  - 000 SB: byte lane enable from addr[1:0], data from wdata[7:0].
  - 001 SH: halfword lanes from addr[1], data from wdata[15:0].
  - 010 SW: all four byte lanes.
- Rejects:
  - Causes: halfword access with addr[0]=1, word access with addr[1:0]!=0, or func3 in {011,110,111}.
  - Effect: no array write, rdata=0, and io_dm_valid=1 with io_dm_misalign=1.
- Store responses: io_dm_valid=1 and rdata=0.

## Timing
- Reset values:
  - io_if_valid, io_dm_valid, io_dm_misalign, io_if_inst and io_dm_rdata are all 0.
  - io_ready=0, or 1 if BOOT_SKIP=1.
  - io_ld_ready=1, or 0 if BOOT_SKIP=1.
- Fetch and load latency is 1 cycle. A request in cycle N gives valid and data in cycle N+1. Outputs hold their value until the next request.
- Valid pulses are single-cycle. Back-to-back requests every cycle are supported; there is no backpressure.
- Stores commit at the edge ending the request cycle. A load or fetch of the same word in the next cycle sees the new data.
- Collision rule: a fetch or load in the same cycle as a store to the same word returns the old data (read-before-write).
- Loader: a byte accepted in cycle N is visible to a RUN fetch from cycle N+1 onward. io_ready rises in the cycle after the last byte is accepted.
- Reset asserted mid-LOAD: return to LOAD with ptr=0. Array contents are retained and in-flight valids drop immediately.
- Reset asserted mid-RUN: return to LOAD (or RUN if BOOT_SKIP=1). Array contents are retained.

## Test plan
- Boot load:
  - Stimulus: stream bytes 13 00 00 00 93 00 10 00, last on the 8th byte, then fetch addr 0 with FETCH_WIDTH=2.
  - Response: io_ready=1 one cycle after the last byte; inst_0=0x00000013 and inst_1=0x00100093, valid one cycle after the request.
- Extension:
  - Stimulus: SW 0x80FF7F01 at 0x100, then LB, LBU, LH and LHU at 0x103 and 0x102.
  - Response: LB@0x103 = 0xFFFFFF80, LBU@0x103 = 0x00000080, LH@0x102 = 0xFFFF80FF, LHU@0x102 = 0x000080FF.
- Partial stores:
  - Stimulus: SW 0 at 0x200; SB 0xAA at 0x201; SH 0x1234 at 0x202; then LW 0x200.
  - Response: LW returns 0x1234AA00.
- Misalign and illegal func3:
  - Stimulus: LW at 0x102; SH at 0x201; func3=011 at 0x200.
  - Response: each gives io_dm_misalign=1 and rdata=0. A following LW 0x200 is unchanged.
- Wrap and collision:
  - Stimulus: fetch the last word of memory.
  - Response: lane 1 returns word 0.
  - Stimulus: SW 0xDEADBEEF and a fetch of the same address in the same cycle.
  - Response: the fetch returns the old data; a fetch in the next cycle returns 0xDEADBEEF.
- Reset mid-load:
  - Stimulus: load 3 bytes, assert reset, then load 4 bytes with last.
  - Response: the new bytes land at addresses 0..3, and io_if_valid stays 0 while in LOAD.
